// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes, default datapath width and the divider state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] MUT  = 6'b011000;
  localparam logic [5:0] DIV  = 6'b011010;
  localparam logic [5:0] DIVU = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on the {rem, quo} pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH:0]   trial;

  // rem stays below the divisor, so its top bit is always dropped by the shift
  assign sh     = {rem_in, quo_in} << 1;
  assign rem_sh = sh[2*WIDTH:WIDTH];
  assign quo_sh = sh[WIDTH-1:0];
  assign trial  = rem_sh - {1'b0, divisor};

  always_comb begin
    rem_out = rem_sh;
    quo_out = quo_sh;
    if (!trial[WIDTH]) begin
      rem_out = trial;
      quo_out = {quo_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/divu_unit.sv
// Sequential restoring divider (DIVU) with start/busy/done handshake; quotient on LoOut, remainder on HiOut.
// Build option: define DIV_SIGNED_EN to also accept signed DIV with sign fix-up folded into the last step.
module divu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  div_state_t state, state_nx;

  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] quo_n;

  logic             fn_ok;
  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvs),
    .rem_out (rem_n),
    .quo_out (quo_n)
  );

`ifdef DIV_SIGNED_EN
  logic sgn_op;
  logic neg_a, neg_b;
  logic neg_q, neg_r;

  assign sgn_op = (Signal == DIV);
  assign fn_ok  = (Signal == DIVU) || sgn_op;
  assign neg_a  = sgn_op && dataA[WIDTH-1];
  assign neg_b  = sgn_op && dataB[WIDTH-1];
  assign mag_a  = neg_a ? (~dataA + 1'b1) : dataA;
  assign mag_b  = neg_b ? (~dataB + 1'b1) : dataB;
  assign q_fin  = neg_q ? (~quo_n + 1'b1) : quo_n;
  assign r_fin  = neg_r ? (~rem_n[WIDTH-1:0] + 1'b1) : rem_n[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
    end
  end
`else
  assign fn_ok = (Signal == DIVU);
  assign mag_a = dataA;
  assign mag_b = dataB;
  assign q_fin = quo_n;
  assign r_fin = rem_n[WIDTH-1:0];
`endif

  assign accept = (state == IDLE) && start && fn_ok;
  assign b_zero = (dataB == '0);

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = b_zero ? FIN : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nx = FIN;
      end
      FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Results are written on the edge into FIN so they are valid alongside done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      divByZero <= 1'b0;
      HiOut     <= '0;
      LoOut     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rem       <= '0;
          quo       <= mag_a;
          dvs       <= mag_b;
          cnt       <= CNT_W'(WIDTH);
          divByZero <= b_zero;
          if (b_zero) begin
            HiOut <= dataA;
            LoOut <= '1;
          end
        end
        RUN: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            HiOut <= r_fin;
            LoOut <= q_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divu_unit.sv
// Directed bench for divu_unit: latency, handshake, divide-by-zero, async reset and optional signed DIV.
module tb_divu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB;
  logic        busy, done, divByZero;
  logic [31:0] HiOut, LoOut;

  int total = 0;
  int bad   = 0;
  int lat, bcnt;

  localparam logic [5:0] F_DIVU = 6'b011011;
  localparam logic [5:0] F_DIV  = 6'b011010;

  divu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Signal    (Signal),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .HiOut     (HiOut),
    .LoOut     (LoOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = f;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accept edge until done; lat=0 means it never came.
  task automatic wait_done(input int k0, input bit inj, output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int k = k0 + 1; k <= 45; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (inj && k == 10) begin
        start = 1'b1;
        dataA = 32'd9;
        dataB = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    Signal = F_DIVU;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz",  {31'd0, divByZero}, 32'd0);
    chk("rst_hi",   HiOut, 32'd0);
    chk("rst_lo",   LoOut, 32'd0);
    reset = 1'b1;

    // 100 / 7
    launch(32'd100, 32'd7, F_DIVU);
    wait_done(0, 1'b0, lat, bcnt);
    chk("t1_lat",  lat, 32'd33);
    chk("t1_busy", bcnt, 32'd33);
    chk("t1_lo",   LoOut, 32'd14);
    chk("t1_hi",   HiOut, 32'd2);
    chk("t1_dbz",  {31'd0, divByZero}, 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_idle_busy",  {31'd0, busy}, 32'd0);

    // max dividend / 1, then small / max divisor
    launch(32'hFFFF_FFFF, 32'd1, F_DIVU);
    wait_done(0, 1'b0, lat, bcnt);
    chk("t2a_lat", lat, 32'd33);
    chk("t2a_lo",  LoOut, 32'hFFFF_FFFF);
    chk("t2a_hi",  HiOut, 32'd0);
    launch(32'd5, 32'hFFFF_FFFF, F_DIVU);
    wait_done(0, 1'b0, lat, bcnt);
    chk("t2b_lat", lat, 32'd33);
    chk("t2b_lo",  LoOut, 32'd0);
    chk("t2b_hi",  HiOut, 32'd5);

    // divide by zero
    launch(32'd1234, 32'd0, F_DIVU);
    wait_done(0, 1'b0, lat, bcnt);
    chk("dbz_lat",  lat, 32'd1);
    chk("dbz_busy", bcnt, 32'd1);
    chk("dbz_flag", {31'd0, divByZero}, 32'd1);
    chk("dbz_hi",   HiOut, 32'd1234);
    chk("dbz_lo",   LoOut, 32'hFFFF_FFFF);

    // async reset during cycle 15 of a division
    launch(32'd100, 32'd7, F_DIVU);
    repeat (15) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_hi",   HiOut, 32'd0);
    chk("ar_lo",   LoOut, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    launch(32'd8, 32'd3, F_DIVU);
    wait_done(0, 1'b0, lat, bcnt);
    chk("ar2_lat", lat, 32'd33);
    chk("ar2_lo",  LoOut, 32'd2);
    chk("ar2_hi",  HiOut, 32'd2);

    // start while busy is ignored, then back-to-back
    launch(32'd100, 32'd7, F_DIVU);
    wait_done(0, 1'b1, lat, bcnt);
    chk("t4_lat", lat, 32'd33);
    chk("t4_lo",  LoOut, 32'd14);
    chk("t4_hi",  HiOut, 32'd2);
    launch(32'd9, 32'd3, F_DIVU);
    repeat (5) @(negedge clk);
    chk("t4_hold_lo", LoOut, 32'd14);
    chk("t4_hold_hi", HiOut, 32'd2);
    wait_done(5, 1'b0, lat, bcnt);
    chk("b2b_lat", lat, 32'd33);
    chk("b2b_lo",  LoOut, 32'd3);
    chk("b2b_hi",  HiOut, 32'd0);

    // wrong funct is ignored
    launch(32'd50, 32'd5, 6'b010000);
    wait_done(0, 1'b0, lat, bcnt);
    chk("nf_done", lat, 32'd0);
    chk("nf_busy", bcnt, 32'd0);

    // signed DIV
    launch(32'hFFFF_FFF9, 32'd2, F_DIV);
    wait_done(0, 1'b0, lat, bcnt);
`ifdef DIV_SIGNED_EN
    chk("sg_lat", lat, 32'd33);
    chk("sg_lo",  LoOut, 32'hFFFF_FFFD);
    chk("sg_hi",  HiOut, 32'hFFFF_FFFF);
    launch(32'h8000_0000, 32'hFFFF_FFFF, F_DIV);
    wait_done(0, 1'b0, lat, bcnt);
    chk("sg_ovf_lo", LoOut, 32'h8000_0000);
    chk("sg_ovf_hi", HiOut, 32'd0);
`else
    chk("sg_off_done", lat, 32'd0);
    chk("sg_off_busy", bcnt, 32'd0);
    chk("sg_off_lo",   LoOut, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divu_unit.md
Name: divu_unit

Overview:
Sequential unsigned divider for the MIPS ALU datapath, implementing DIVU (funct 6'b011011).
- Performs one restoring-division step per clock on 32-bit operands.
- Writes quotient to the Lo output and remainder to the Hi output, which feed the MFHI/MFLO selection path.
- Uses a start/busy/done handshake driven by the ALU control logic.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
Signal  input  6  funct code; operation accepted only if DIVU (or DIV when the optional feature is compiled in)
dataA  input  WIDTH  dividend, sampled on the accepted start cycle
dataB  input  WIDTH  divisor, sampled on the accepted start cycle
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse when HiOut/LoOut are updated
divByZero  output  1  high with done when divisor was 0; holds until next accept
HiOut  output  WIDTH  remainder of last completed operation
LoOut  output  WIDTH  quotient of last completed operation

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, divByZero=0, HiOut=0, LoOut=0, counter=0. Reset mid-operation aborts and discards the operation.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 and Signal==DIVU → latch operands; load remainder reg (WIDTH+1 bits)=0, quotient reg=dataA, counter=WIDTH, divisor reg=dataB; clear divByZero; go to RUN.
  - start with any other Signal is ignored; stay IDLE.
  - start=1 with dataB==0 → go to FIN directly (no iterations).
- RUN, each cycle:
  - Shift {rem,quo} left by 1.
  - trial = rem − {0,divisor}.
  - If trial is non-negative (MSB=0): rem=trial and quo[0]=1; else quo[0]=0.
  - counter−1; at counter==1 go to FIN.
- FIN:
  - HiOut=rem[WIDTH−1:0], LoOut=quo; done=1 for exactly this cycle; return to IDLE.
  - Divide by zero: HiOut=dataA, LoOut=all ones, divByZero=1.
- Latency:
  - Accept at edge N → done high in cycle N+WIDTH+1 (33 for WIDTH=32).
  - Divide by zero: done in cycle N+1.
- busy=1 in RUN and FIN, 0 in IDLE.
- start while busy is ignored (no queuing); operands are never re-sampled mid-operation.
- A new start is accepted in the cycle after done (back-to-back allowed).
- HiOut/LoOut change only at FIN and hold otherwise, including while a new division runs.
- Unsigned arithmetic only (without the optional feature); no overflow case exists for DIVU.

Optional Feature:
Macro DIV_SIGNED_EN.
- Defined:
  - Signal==DIV (6'b011010) is also accepted.
  - On accept, operands are converted to magnitudes and sign flags are latched.
  - At FIN: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0.
  - Latency is unchanged (sign fix-up is folded into FIN).
- Not defined: DIV is ignored like any other non-DIVU funct; no sign logic is synthesised.

Decomposition:
- Shared package alu_pkg: funct constants DIVU, DIV, MFHI, MFLO, MUT; WIDTH default; state enum (IDLE/RUN/FIN).
- One natural sub-module, div_step: combinational single restoring iteration (rem_in, quo_in, divisor → rem_out, quo_out). Instantiated once in the sequential wrapper.

Test Plan:
- dataA=100, dataB=7, Signal=DIVU, start pulse → done exactly 33 cycles later; LoOut=14, HiOut=2; busy high 33 cycles.
- dataA=0xFFFFFFFF, dataB=1 → LoOut=0xFFFFFFFF, HiOut=0; then dataA=5, dataB=0xFFFFFFFF → LoOut=0, HiOut=5.
- dataA=1234, dataB=0 → done one cycle after accept; divByZero=1, HiOut=1234, LoOut=0xFFFFFFFF.
- Start 100/7; at cycle 10 pulse start with 9/3 → second request ignored, result still 14/2; back-to-back start 9/3 right after done → LoOut=3, HiOut=0.
- Drive reset=0 at cycle 15 of a division → busy, done, HiOut, LoOut go to 0 immediately (asynchronous); after release, new 8/3 → 2/2.
- With DIV_SIGNED_EN: Signal=DIV, dataA=−7 (0xFFFFFFF9), dataB=2 → LoOut=0xFFFFFFFD (−3), HiOut=0xFFFFFFFF (−1). Without the macro, the same stimulus produces no busy and no done.
